memory_access: RTL and testbench

- Pipeline stage directly downstream of the execute stage. Consumes its registered outputs (ALU result as address, store data, load/store controls, WB fields).
- Performs at most one data-bus transaction per instruction over a request/grant + response handshake, with lane steering and alignment checks.
- Registers results for write-back. Raises a busy stall toward the hazard unit while an access is outstanding.

---
 rtl/memory_access.sv | 232 +++++++++++++++++++++++
 tb/tb_memory_access.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: pipeline stage after execute. Issues at most one data-bus
// access per instruction (request/grant, then response for loads), steers
// store lanes, extends load data, flags misaligned accesses, and registers
// everything for write-back. busy stalls earlier stages while an access is
// outstanding.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   *_in                instruction fields from execute (alu_data_in = address)
//   stall, invalidate   downstream hold / flush of this stage
//   data_hazard, busy   to hazard unit
//   mem_*               data-bus request/grant + response handshake
//   *_out               registered results for write-back
module memory_access #(
    parameter logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4,
    parameter logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] csr_data_in,
    input  logic        branch_taken_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [1:0]  load_store_size_in,
    input  logic        load_signed_in,
    input  logic [1:0]  write_select_in,
    input  logic [5:0]  rd_addr_in,
    input  logic [11:0] csr_addr_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        stall,
    input  logic        invalidate,
    output logic [4:0]  data_hazard,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] csr_data_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] load_data_out,
    output logic        branch_taken_out,
    output logic        mret_out,
    output logic        wfi_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [1:0]  write_select_out,
    output logic [5:0]  rd_addr_out,
    output logic [11:0] csr_addr_out,
    output logic [3:0]  ecause_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state, state_next;
    logic        done;
    logic [31:0] rbuf;
    logic        active, misaligned, mem_op, mis_fault, is_access, to_access;
    logic        req, complete, accept;
    logic [31:0] load_raw, load_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign active     = valid_in && !exception_in && !invalidate;
    assign misaligned = ((load_store_size_in == 2'd1) && alu_data_in[0]) ||
                        (load_store_size_in[1] && (alu_data_in[1:0] != 2'b00));
    assign mem_op     = load_in || store_in;
    assign mis_fault  = mem_op && misaligned;
    assign is_access  = active && mem_op && !misaligned;
    // done marks an access already finished but not yet taken by the output
    // registers (stall high); it suppresses a second request.
    assign to_access  = is_access && !done;

    always_comb begin
        state_next = state;
        req        = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                req = to_access;
                if (to_access) begin
                    if (!mem_gnt)      state_next = S_REQ;
                    else if (store_in) complete   = 1'b1;
                    else               state_next = S_RSP;
                end
            end
            S_REQ: begin
                if (!to_access) begin
                    state_next = S_IDLE;
                end else begin
                    req = 1'b1;
                    if (mem_gnt) begin
                        if (store_in) begin
                            complete   = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_RSP;
                        end
                    end
                end
            end
            S_RSP: begin
                // A granted load is always drained; a flushed one just drops its data.
                if (mem_rvalid) begin
                    if (!active) begin
                        state_next = S_IDLE;
                    end else if (stall) begin
                        state_next = S_HOLD;
                    end else begin
                        complete   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                if (!active) begin
                    state_next = S_IDLE;
                end else if (!stall) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    assign mem_req     = req && !reset;
    assign busy        = !reset && (((state == S_RSP) && !mem_rvalid) || (to_access && !complete));
    assign accept      = !stall && !busy;
    assign data_hazard = active ? rd_addr_in[4:0] : '0;
    assign mem_write   = store_in;
    assign mem_addr    = {alu_data_in[31:2], 2'b00};

    always_comb begin
        mem_wdata = rs2_data_in;
        mem_strb  = 4'b1111;
        case (load_store_size_in)
            2'd0: begin
                mem_wdata = {4{rs2_data_in[7:0]}};
                mem_strb  = 4'b0001 << alu_data_in[1:0];
            end
            2'd1: begin
                mem_wdata = {2{rs2_data_in[15:0]}};
                mem_strb  = alu_data_in[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_raw = (state == S_HOLD) ? rbuf : mem_rdata;
        case (alu_data_in[1:0])
            2'd0:    lane_b = load_raw[7:0];
            2'd1:    lane_b = load_raw[15:8];
            2'd2:    lane_b = load_raw[23:16];
            default: lane_b = load_raw[31:24];
        endcase
        lane_h = alu_data_in[1] ? load_raw[31:16] : load_raw[15:0];
        case (load_store_size_in)
            2'd0:    load_ext = {{24{load_signed_in && lane_b[7]}}, lane_b};
            2'd1:    load_ext = {{16{load_signed_in && lane_h[15]}}, lane_h};
            default: load_ext = load_raw;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
            rbuf  <= '0;
        end else begin
            state <= state_next;
            if (!stall)        done <= 1'b0;
            else if (complete) done <= 1'b1;
            if ((state == S_RSP) && mem_rvalid) rbuf <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out           <= '0;
            next_pc_out      <= '0;
            csr_data_out     <= '0;
            alu_data_out     <= '0;
            load_data_out    <= '0;
            branch_taken_out <= 1'b0;
            mret_out         <= 1'b0;
            wfi_out          <= 1'b0;
            valid_out        <= 1'b0;
            exception_out    <= 1'b0;
            write_select_out <= '0;
            rd_addr_out      <= '0;
            csr_addr_out     <= '0;
            ecause_out       <= '0;
        end else if (accept) begin
            pc_out           <= pc_in;
            next_pc_out      <= next_pc_in;
            csr_data_out     <= csr_data_in;
            alu_data_out     <= alu_data_in;
            load_data_out    <= (active && load_in && !misaligned) ? load_ext : '0;
            branch_taken_out <= branch_taken_in;
            mret_out         <= mret_in;
            wfi_out          <= wfi_in;
            valid_out        <= valid_in && !invalidate;
            exception_out    <= valid_in && !invalidate && (exception_in || mis_fault);
            write_select_out <= write_select_in;
            rd_addr_out      <= rd_addr_in;
            csr_addr_out     <= csr_addr_in;
            // An incoming fault keeps its own cause over a misalignment.
            if (!exception_in && mis_fault)
                ecause_out <= store_in ? ECAUSE_STORE_MISALIGNED : ECAUSE_LOAD_MISALIGNED;
            else
                ecause_out <= ecause_in;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    typedef struct {
        logic [31:0] pc, npc, alu, rs2, csr;
        logic        br, load, store, sgn, mret, wfi, valid, exc;
        logic [1:0]  size, wsel;
        logic [5:0]  rd;
        logic [11:0] csra;
        logic [3:0]  ecause;
    } instr_t;

    typedef struct {
        logic [31:0] pc, npc, csr, alu, ld;
        logic        br, mret, wfi, valid, exc;
        logic [1:0]  wsel;
        logic [5:0]  rd;
        logic [11:0] csra;
        logic [3:0]  ecause;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
    logic        branch_taken_in, load_in, store_in, load_signed_in, mret_in, wfi_in;
    logic        valid_in, exception_in, stall, invalidate, mem_gnt, mem_rvalid;
    logic [1:0]  load_store_size_in, write_select_in;
    logic [5:0]  rd_addr_in;
    logic [11:0] csr_addr_in;
    logic [3:0]  ecause_in;
    logic [31:0] mem_rdata;
    logic [4:0]  data_hazard;
    logic        busy, mem_req, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic [31:0] pc_out, next_pc_out, csr_data_out, alu_data_out, load_data_out;
    logic        branch_taken_out, mret_out, wfi_out, valid_out, exception_out;
    logic [1:0]  write_select_out;
    logic [5:0]  rd_addr_out;
    logic [11:0] csr_addr_out;
    logic [3:0]  ecause_out;

    memory_access #(
        .ECAUSE_LOAD_MISALIGNED (4'd4),
        .ECAUSE_STORE_MISALIGNED(4'd6)
    ) dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
        .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
        .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
        .load_store_size_in(load_store_size_in), .load_signed_in(load_signed_in),
        .write_select_in(write_select_in), .rd_addr_in(rd_addr_in),
        .csr_addr_in(csr_addr_in), .mret_in(mret_in), .wfi_in(wfi_in),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .stall(stall), .invalidate(invalidate),
        .data_hazard(data_hazard), .busy(busy),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .csr_data_out(csr_data_out),
        .alu_data_out(alu_data_out), .load_data_out(load_data_out),
        .branch_taken_out(branch_taken_out), .mret_out(mret_out), .wfi_out(wfi_out),
        .valid_out(valid_out), .exception_out(exception_out),
        .write_select_out(write_select_out), .rd_addr_out(rd_addr_out),
        .csr_addr_out(csr_addr_out), .ecause_out(ecause_out)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    logic   chk_en = 1'b0;
    instr_t cur;
    out_t   exp_out;
    logic   exp_req, exp_busy, exp_write;
    logic [4:0]  exp_haz;
    logic [31:0] exp_addr, exp_wdata, captured;
    logic [3:0]  exp_strb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input instr_t i);
        return (i.alu % nbytes(i.size)) != 0;
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] raw, input instr_t i);
        int unsigned v;
        int unsigned r;
        r = raw;
        if (i.size == 2'd0) begin
            v = (r >> (8 * (i.alu % 4))) % 256;
            if (i.sgn && v >= 128) v = v + 32'hFFFFFF00;
        end else if (i.size == 2'd1) begin
            v = (r >> (16 * ((i.alu / 2) % 2))) % 65536;
            if (i.sgn && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_wdata(input instr_t i);
        if (i.size == 2'd0) return (i.rs2 % 256) * 32'h01010101;
        if (i.size == 2'd1) return (i.rs2 % 65536) * 32'h00010001;
        return i.rs2;
    endfunction

    function automatic logic [3:0] f_strb(input instr_t i);
        int unsigned a;
        a = i.alu % 4;
        if (i.size == 2'd0) return 4'(1 << a);
        if (i.size == 2'd1) return 4'(3 << (a - a % 2));
        return 4'hF;
    endfunction

    function automatic out_t model_out(input instr_t i, input logic inv, input logic [31:0] raw);
        out_t o;
        logic act, memop;
        act   = i.valid && !i.exc && !inv;
        memop = i.load || i.store;
        o.pc = i.pc; o.npc = i.npc; o.csr = i.csr; o.alu = i.alu;
        o.br = i.br; o.mret = i.mret; o.wfi = i.wfi; o.wsel = i.wsel;
        o.rd = i.rd; o.csra = i.csra;
        o.valid  = i.valid && !inv;
        o.exc    = i.valid && !inv && (i.exc || (memop && is_mis(i)));
        o.ecause = (!i.exc && memop && is_mis(i)) ? (i.store ? 4'd6 : 4'd4) : i.ecause;
        o.ld     = (act && i.load && !is_mis(i)) ? ext_load(raw, i) : 32'h0;
        return o;
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, alu, rs2, input logic ld, st,
                                  input logic [1:0] sz, input logic sg, input logic [5:0] rd);
        instr_t i;
        i = '{default: '0};
        i.pc = pc; i.npc = pc + 32'd4; i.alu = alu; i.rs2 = rs2;
        i.load = ld; i.store = st; i.size = sz; i.sgn = sg; i.rd = rd; i.valid = 1'b1;
        i.csr = pc ^ 32'h5A5A0000; i.csra = pc[13:2]; i.wsel = pc[3:2];
        i.br = pc[4]; i.mret = pc[5]; i.wfi = pc[6];
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    // One clock cycle with bus/stall/flush inputs and hand-derived req/busy.
    task automatic step(input logic gnt, rv, input logic [31:0] rd_data,
                        input logic stl, inv, e_req, e_busy);
        pc_in = cur.pc; next_pc_in = cur.npc; alu_data_in = cur.alu; rs2_data_in = cur.rs2;
        csr_data_in = cur.csr; branch_taken_in = cur.br; load_in = cur.load;
        store_in = cur.store; load_store_size_in = cur.size; load_signed_in = cur.sgn;
        write_select_in = cur.wsel; rd_addr_in = cur.rd; csr_addr_in = cur.csra;
        mret_in = cur.mret; wfi_in = cur.wfi; valid_in = cur.valid;
        exception_in = cur.exc; ecause_in = cur.ecause;
        mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rv ? rd_data : 32'h0;
        stall = stl; invalidate = inv;
        if (rv) captured = rd_data;
        exp_req   = e_req;
        exp_busy  = e_busy;
        exp_haz   = (cur.valid && !cur.exc && !inv) ? cur.rd[4:0] : 5'd0;
        exp_addr  = cur.alu & 32'hFFFFFFFC;
        exp_wdata = f_wdata(cur);
        exp_strb  = f_strb(cur);
        exp_write = cur.store;
        @(posedge clk);
        if (!stl && !e_busy) exp_out = model_out(cur, inv, captured);
        #1;
    endtask

    task automatic idle();
        cur = nop();
        captured = 32'h0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, exp_req);
            chk("busy", busy, exp_busy);
            chk("data_hazard", data_hazard, exp_haz);
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("mem_strb", mem_strb, exp_strb);
                chk("mem_write", mem_write, exp_write);
            end
            chk("pc_out", pc_out, exp_out.pc);
            chk("next_pc_out", next_pc_out, exp_out.npc);
            chk("csr_data_out", csr_data_out, exp_out.csr);
            chk("alu_data_out", alu_data_out, exp_out.alu);
            chk("load_data_out", load_data_out, exp_out.ld);
            chk("branch_taken_out", branch_taken_out, exp_out.br);
            chk("mret_out", mret_out, exp_out.mret);
            chk("wfi_out", wfi_out, exp_out.wfi);
            chk("valid_out", valid_out, exp_out.valid);
            chk("exception_out", exception_out, exp_out.exc);
            chk("write_select_out", write_select_out, exp_out.wsel);
            chk("rd_addr_out", rd_addr_out, exp_out.rd);
            chk("csr_addr_out", csr_addr_out, exp_out.csra);
            chk("ecause_out", ecause_out, exp_out.ecause);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_out = '{default: '0};
        exp_req = 1'b0; exp_busy = 1'b0; exp_haz = '0; captured = '0;
        cur = nop();
        reset = 1'b1;
        pc_in = '0; next_pc_in = '0; alu_data_in = '0; rs2_data_in = '0; csr_data_in = '0;
        branch_taken_in = 0; load_in = 0; store_in = 0; load_store_size_in = '0;
        load_signed_in = 0; write_select_in = '0; rd_addr_in = '0; csr_addr_in = '0;
        mret_in = 0; wfi_in = 0; valid_in = 0; exception_in = 0; ecause_in = '0;
        stall = 0; invalidate = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset valid_out", valid_out, 1'b0);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset load_data_out", load_data_out, 32'h0);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset busy", busy, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        idle();

        // Word load at 0x100: gnt at once, two empty response cycles, then rvalid.
        cur = mk(32'h0000_1074, 32'h100, 32'h0, 1, 0, 2'd2, 0, 6'h25);
        step(1, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("word load data", load_data_out, 32'hDEADBEEF);
        chk("word load valid", valid_out, 1'b1);
        idle();

        // Signed byte load at 0x103.
        cur = mk(32'h0000_2008, 32'h103, 32'h0, 1, 0, 2'd0, 1, 6'h03);
        step(1, 0, 0, 0, 0, 1, 1);
        step(0, 1, 32'h80FFFFFF, 0, 0, 0, 0);
        chk("signed byte load", load_data_out, 32'hFFFFFF80);
        idle();

        // Unsigned halfword load at 0x102.
        cur = mk(32'h0000_2010, 32'h102, 32'h0, 1, 0, 2'd1, 0, 6'h04);
        step(1, 0, 0, 0, 0, 1, 1);
        step(0, 1, 32'h80FFFFFF, 0, 0, 0, 0);
        chk("unsigned half load", load_data_out, 32'h000080FF);
        idle();

        // Byte store at 0x201, grant after three waiting cycles.
        cur = mk(32'h0000_3020, 32'h201, 32'h12345678, 0, 1, 2'd0, 0, 6'h00);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("byte store strb", mem_strb, 4'b0010);
        chk("byte store wdata", mem_wdata, 32'h78787878);
        idle();

        // Halfword store at 0x202 lands in the upper lanes.
        cur = mk(32'h0000_3040, 32'h202, 32'hCAFE1234, 0, 1, 2'd1, 0, 6'h00);
        step(1, 0, 0, 0, 0, 1, 0);
        idle();

        // Misaligned accesses raise a fault instead of a request.
        cur = mk(32'h0000_4000, 32'h101, 32'h0, 1, 0, 2'd1, 0, 6'h07);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("misaligned load exc", exception_out, 1'b1);
        chk("misaligned load ecause", ecause_out, 4'd4);
        cur = mk(32'h0000_4004, 32'h102, 32'h0, 0, 1, 2'd2, 0, 6'h00);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("misaligned store ecause", ecause_out, 4'd6);
        cur = mk(32'h0000_4008, 32'h103, 32'h0, 0, 1, 2'd2, 0, 6'h00);
        cur.exc = 1'b1; cur.ecause = 4'd2;
        step(0, 0, 0, 0, 0, 0, 0);
        chk("prior exception ecause", ecause_out, 4'd2);
        idle();

        // Response arrives under stall: held, then registered once on release.
        cur = mk(32'h0000_5000, 32'h300, 32'h0, 1, 0, 2'd2, 0, 6'h09);
        step(1, 0, 0, 0, 0, 1, 1);
        step(0, 1, 32'hCAFEF00D, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("held load data", load_data_out, 32'hCAFEF00D);
        idle();

        // Store granted under stall issues no second request.
        cur = mk(32'h0000_5100, 32'h305, 32'h000000A5, 0, 1, 2'd0, 0, 6'h00);
        step(1, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle();

        // Flush while waiting for the response: busy until rvalid, data dropped.
        cur = mk(32'h0000_6000, 32'h400, 32'h0, 1, 0, 2'd2, 0, 6'h0A);
        step(1, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 1, 32'h11111111, 0, 1, 0, 0);
        chk("flushed valid_out", valid_out, 1'b0);
        chk("flushed load_data", load_data_out, 32'h0);
        idle();

        // Flush while requesting drops the request at once.
        cur = mk(32'h0000_6100, 32'h404, 32'h0, 1, 0, 2'd2, 0, 6'h0B);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        idle();

        // Asynchronous reset while a request is pending.
        cur = mk(32'h0000_7000, 32'h500, 32'h0, 1, 0, 2'd2, 0, 6'h0C);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async reset mem_req", mem_req, 1'b0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset pc_out", pc_out, 32'h0);
        chk("async reset valid_out", valid_out, 1'b0);
        exp_out = '{default: '0};
        cur = nop();
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
